// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the 16-deep async FIFO (clk_WR domain).
// Packet-locked bursts from 4 requesters, 2-bit source tag, flush sequencing via fifo_srst.
module fifo_wr_arbiter #(
  parameter int DATA_W     = 6,
  parameter int MAX_BURST  = 8,
  parameter int FLUSH_WAIT = 4
) (
  input  logic                clk_WR,
  input  logic                rst,
  input  logic [3:0]          req_valid,
  input  logic [4*DATA_W-1:0] req_data,
  input  logic [3:0]          req_last,
  output logic [3:0]          req_ready,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [DATA_W+1:0]   fifo_din,
  output logic                fifo_srst,
  input  logic                flush,
  output logic                flush_busy,
  output logic                gnt_valid,
  output logic [1:0]          gnt_id
);

  // state   | meaning
  // S_IDLE  | pick next requester round-robin from rr_ptr
  // S_GRANT | requester gnt_id_q owns the FIFO write port until last/MAX_BURST
  // S_FLUSH | fifo_srst pulse on the first cycle, then FLUSH_WAIT cycles of hold-off
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FLUSH} state_t;

  localparam logic [3:0] MAX_B  = 4'(MAX_BURST);
  localparam logic [3:0] FWAIT  = 4'(FLUSH_WAIT);

  state_t      state, state_nx;
  logic [1:0]  rr_ptr, rr_nx;
  logic [1:0]  gnt_id_q, gnt_nx;
  logic [3:0]  beat_cnt, beat_nx;
  logic [3:0]  flush_cnt, fcnt_nx;
  logic        srst_q, srst_nx;

  logic        sel_found;
  logic [1:0]  sel_id;
  logic [1:0]  idx;
  logic [DATA_W-1:0] cur_data;
  logic        beat;
  logic        burst_end;

  always_ff @(posedge clk_WR or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= 2'd0;
      gnt_id_q  <= 2'd0;
      beat_cnt  <= 4'd0;
      flush_cnt <= 4'd0;
      srst_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      gnt_id_q  <= gnt_nx;
      beat_cnt  <= beat_nx;
      flush_cnt <= fcnt_nx;
      srst_q    <= srst_nx;
    end
  end

  // First valid requester at or after rr_ptr, wrapping mod 4
  always_comb begin
    sel_found = 1'b0;
    sel_id    = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  always_comb begin
    cur_data  = req_data[gnt_id_q*DATA_W +: DATA_W];
    beat      = (state == S_GRANT) && !flush && req_valid[gnt_id_q] && !fifo_full;
    burst_end = beat && (req_last[gnt_id_q] || (beat_cnt + 4'd1 == MAX_B));

    req_ready = 4'b0000;
    if ((state == S_GRANT) && !flush && !fifo_full)
      req_ready[gnt_id_q] = 1'b1;

    fifo_wr    = beat;
    fifo_din   = beat ? {gnt_id_q, cur_data} : '0;
    fifo_srst  = srst_q;
    flush_busy = (state == S_FLUSH);
    gnt_valid  = (state == S_GRANT);
    gnt_id     = gnt_id_q;
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    gnt_nx   = gnt_id_q;
    beat_nx  = beat_cnt;
    fcnt_nx  = flush_cnt;
    srst_nx  = flush && (state != S_FLUSH);

    if (flush) begin
      // Re-flush inside FLUSH only reloads the hold-off counter
      state_nx = S_FLUSH;
      fcnt_nx  = FWAIT;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found && !fifo_full) begin
            gnt_nx   = sel_id;
            beat_nx  = 4'd0;
            state_nx = S_GRANT;
          end
        end
        S_GRANT: begin
          if (beat)
            beat_nx = beat_cnt + 4'd1;
          if (burst_end) begin
            state_nx = S_IDLE;
            rr_nx    = gnt_id_q + 2'd1;
          end
        end
        S_FLUSH: begin
          // The srst cycle itself does not count toward the hold-off
          if (!srst_q) begin
            if (flush_cnt <= 4'd1) begin
              state_nx = S_IDLE;
              rr_nx    = 2'd0;
            end else begin
              fcnt_nx = flush_cnt - 4'd1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle vector table, burst/reset/flush sequences,
// and a random-packet scoreboard against per-requester source queues with a 16-deep FIFO model.
module tb_fifo_wr_arbiter;
  localparam int DW = 6;

  logic          clk_WR;
  logic          rst;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_last;
  logic [3:0]    req_ready;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW+1:0] fifo_din;
  logic          fifo_srst;
  logic          flush;
  logic          flush_busy;
  logic          gnt_valid;
  logic [1:0]    gnt_id;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(8), .FLUSH_WAIT(4)) dut (
    .clk_WR(clk_WR), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_srst(fifo_srst), .flush(flush),
    .flush_busy(flush_busy), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  initial clk_WR = 1'b0;
  always #5 clk_WR = ~clk_WR;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       fl;
    logic [3:0] e_ready;
    logic       e_wr;
    logic [7:0] e_din;
    logic       e_srst;
    logic       e_busy;
    logic       e_gv;
    logic [1:0] e_gid;
  } vec_t;

  vec_t vecs[25];

  logic [6:0] sq [4][$];   // {last, data} per requester
  int         id_log[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                              input logic fl, input logic [3:0] r, input logic w,
                              input logic [7:0] d, input logic s, input logic b,
                              input logic g, input logic [1:0] id);
    vec_t t;
    t.valid = v; t.last = l; t.full = f; t.fl = fl;
    t.e_ready = r; t.e_wr = w; t.e_din = d; t.e_srst = s; t.e_busy = b;
    t.e_gv = g; t.e_gid = id;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, req_ready, fifo_wr, fifo_din, fifo_srst, flush_busy, gnt_valid, gnt_id};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; flush = 1'b0; fifo_full = 1'b0;
    repeat (2) @(negedge clk_WR);
    rst = 1'b0;
  endtask

  task automatic run_traffic(input int budget, input bit gaps, input bit use_fifo);
    int cnt = 0;
    int cyc = 0;
    int id;
    bit v;
    while (sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size() > 0) begin
      if (cyc >= budget) begin
        chk("traffic_timeout", 32'(cyc), 32'(budget - 1));
        break;
      end
      @(negedge clk_WR);
      for (int i = 0; i < 4; i++) begin
        v = (sq[i].size() > 0) && (!gaps || $urandom_range(3) != 0);
        req_valid[i] = v;
        req_data[i*DW +: DW] = (sq[i].size() > 0) ? sq[i][0][5:0] : 6'd0;
        req_last[i] = (sq[i].size() > 0) ? sq[i][0][6] : 1'b0;
      end
      fifo_full = use_fifo && (cnt >= 16);
      #1;
      if (fifo_wr) begin
        id = int'(fifo_din[7:6]);
        if (fifo_full) begin
          chk("wr_while_full", 32'(fifo_wr), 32'd0);
        end else if (sq[id].size() == 0) begin
          chk("word_unexpected_src", 32'(id), 32'hFF);
        end else begin
          chk("word", {22'd0, req_ready, fifo_din[5:0]},
              {22'd0, 4'(4'b0001 << id), sq[id][0][5:0]});
          id_log.push_back(id);
          void'(sq[id].pop_front());
          cnt++;
        end
      end
      if (use_fifo && cnt > 0 && $urandom_range(2) == 0) cnt--;
      cyc++;
    end
    @(negedge clk_WR);
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int srst_cnt;
    int total;
    int exp_ids[$];
    logic [5:0] seq [4];

    //                valid    last     full  fl   ready   wr  din    srst busy gv  gid
    vecs[0]  = mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 2'd0);
    vecs[1]  = mk(4'b1111, 4'b1111, 0, 0, 4'b0001, 1, 8'h11, 0, 0, 1, 2'd0);
    vecs[2]  = mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 2'd0);
    vecs[3]  = mk(4'b1111, 4'b1111, 0, 0, 4'b0010, 1, 8'h62, 0, 0, 1, 2'd1);
    vecs[4]  = mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 2'd1);
    vecs[5]  = mk(4'b1111, 4'b1111, 0, 0, 4'b0100, 1, 8'hB3, 0, 0, 1, 2'd2);
    vecs[6]  = mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 2'd2);
    vecs[7]  = mk(4'b1111, 4'b1111, 0, 0, 4'b1000, 1, 8'hFC, 0, 0, 1, 2'd3);
    vecs[8]  = mk(4'b0010, 4'b0010, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 2'd3);
    vecs[9]  = mk(4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 8'h62, 0, 0, 1, 2'd1);
    vecs[10] = mk(4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 2'd1);
    vecs[11] = mk(4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 8'hB3, 0, 0, 1, 2'd2);
    vecs[12] = mk(4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 8'h00, 0, 0, 1, 2'd2);
    vecs[13] = mk(4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 8'h00, 0, 0, 1, 2'd2);
    vecs[14] = mk(4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 8'h00, 0, 0, 1, 2'd2);
    vecs[15] = mk(4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 8'hB3, 0, 0, 1, 2'd2);
    vecs[16] = mk(4'b0001, 4'b0000, 0, 0, 4'b0100, 0, 8'h00, 0, 0, 1, 2'd2);
    vecs[17] = mk(4'b0100, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 0, 1, 2'd2);
    vecs[18] = mk(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 1, 1, 0, 2'd2);
    vecs[19] = mk(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 1, 0, 2'd2);
    vecs[20] = mk(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 1, 0, 2'd2);
    vecs[21] = mk(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 1, 0, 2'd2);
    vecs[22] = mk(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 1, 0, 2'd2);
    vecs[23] = mk(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 2'd2);
    vecs[24] = mk(4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 8'h62, 0, 0, 1, 2'd1);

    rst = 1'b1; req_valid = '0; req_last = '0; flush = 1'b0; fifo_full = 1'b0;
    req_data = {6'h3C, 6'h33, 6'h22, 6'h11};
    #3;
    chk("reset_outputs", outs(), 32'd0);
    do_reset();

    // Cycle-accurate table: round-robin singles, stall, mid-packet gap, flush
    for (int n = 0; n < 25; n++) begin
      @(negedge clk_WR);
      req_valid = vecs[n].valid; req_last = vecs[n].last;
      fifo_full = vecs[n].full;  flush = vecs[n].fl;
      #1;
      chk($sformatf("vec%0d", n), outs(),
          {14'd0, vecs[n].e_ready, vecs[n].e_wr, vecs[n].e_din, vecs[n].e_srst,
           vecs[n].e_busy, vecs[n].e_gv, vecs[n].e_gid});
    end
    flush = 1'b0;

    // MAX_BURST split: 12-word packet from ID2 interleaved with ID3's packet
    do_reset();
    id_log.delete();
    for (int i = 0; i < 12; i++) sq[2].push_back({(i == 11), 6'(i)});
    for (int i = 0; i < 2; i++)  sq[3].push_back({(i == 1), 6'(40 + i)});
    run_traffic(200, 1'b0, 1'b0);
    exp_ids.delete();
    for (int i = 0; i < 8; i++) exp_ids.push_back(2);
    for (int i = 0; i < 2; i++) exp_ids.push_back(3);
    for (int i = 0; i < 4; i++) exp_ids.push_back(2);
    chk("burst_len", 32'(id_log.size()), 32'd14);
    begin
      int bad = 0;
      for (int i = 0; i < exp_ids.size() && i < id_log.size(); i++)
        if (id_log[i] != exp_ids[i]) bad++;
      chk("burst_order_mismatches", 32'(bad), 32'd0);
    end

    // Async reset mid-grant, then lowest valid ID wins
    do_reset();
    req_data = {6'h3C, 6'h33, 6'h22, 6'h11};
    @(negedge clk_WR);
    req_valid = 4'b1000; req_last = 4'b0000;
    @(negedge clk_WR);
    #1;
    chk("pre_rst_grant", {30'd0, fifo_wr, gnt_valid}, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", outs(), 32'd0);
    @(negedge clk_WR);
    req_valid = 4'b1100;
    rst = 1'b0;
    @(negedge clk_WR);
    #1;
    chk("post_rst_grant", {29'd0, gnt_valid, gnt_id}, 32'h6);
    req_valid = '0;

    // Flush re-asserted during FLUSH: one srst, wait restarted
    do_reset();
    busy_cnt = 0; srst_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_WR);
      flush = (k == 0) || (k == 2);
      #1;
      busy_cnt += int'(flush_busy);
      srst_cnt += int'(fifo_srst);
    end
    flush = 1'b0;
    chk("reflush_srst_pulses", 32'(srst_cnt), 32'd1);
    chk("reflush_busy_cycles", 32'(busy_cnt), 32'd6);

    // Random packets against a 16-deep FIFO that drains at random
    do_reset();
    id_log.delete();
    total = 0;
    for (int i = 0; i < 4; i++) seq[i] = 6'd0;
    for (int p = 0; p < 1000; p++) begin
      int src;
      int len;
      src = $urandom_range(3);
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++) begin
        sq[src].push_back({(w == len - 1), seq[src]});
        seq[src] = seq[src] + 6'd1;
        total++;
      end
    end
    run_traffic(60000, 1'b1, 1'b1);
    chk("random_word_count", 32'(id_log.size()), 32'(total));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
